skid_buffer: RTL and testbench
==============================

SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 Parameter W, default 8, data bus width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  W  upstream data word.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  buffer accepts a word this cycle; driven directly from a flop.
REQ-007 out_data  output  W  downstream data word; driven directly from a flop.
REQ-008 out_valid  output  1  out_data holds a word; driven directly from a flop.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 stall_cnt  output  16  count of downstream-stall cycles; present only when SKID_STALL_CNT_EN is defined.

Function
REQ-011 The block SHALL register both directions: data/valid forward and ready backward, with no combinational path from any input to any output.
REQ-012 Transfer definitions: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready, both sampled at the rising edge.
REQ-013 Storage: main register (drives out_data) and one skid register; three-state FSM: EMPTY, BUSY (main full, skid empty), FULL (both full).
REQ-014 in_ready SHALL be 1 in EMPTY and BUSY, 0 in FULL; out_valid SHALL be 1 in BUSY and FULL, 0 in EMPTY.
REQ-015 EMPTY with in_valid: main <= in_data, go to BUSY; otherwise stay in EMPTY.
REQ-016 BUSY with in_valid & out_ready: main <= in_data, stay in BUSY (full throughput).
REQ-017 BUSY with in_valid & !out_ready: skid <= in_data, go to FULL.
REQ-018 BUSY with !in_valid & out_ready: go to EMPTY.
REQ-019 BUSY with !in_valid & !out_ready: hold.
REQ-020 FULL with out_ready: main <= skid, go to BUSY; in_valid is ignored (in_ready is 0).
REQ-021 FULL with !out_ready: hold all state.
REQ-022 Latency: a word accepted at edge N SHALL appear on out_data with out_valid at edge N when the buffer was EMPTY or draining; throughput SHALL be one word per cycle while out_ready stays 1.
REQ-023 Ordering SHALL be strict FIFO; no word is dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 The block SHALL NOT require in_valid to stay asserted once asserted.

Reset
REQ-026 reset_n low SHALL asynchronously force state EMPTY, out_valid=0, in_ready=0, out_data=0, skid=0 and stall_cnt=0.
REQ-027 in_ready SHALL rise on the first clock edge after reset_n deasserts; a reset mid-operation SHALL discard all held words.

Configuration
REQ-028 Macro SKID_STALL_CNT_EN defined: stall_cnt increments on each edge where out_valid=1 and out_ready=0, saturates at 16'hFFFF, and is cleared only by reset.
REQ-029 Macro SKID_STALL_CNT_EN undefined: the stall_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Shared package skid_pkg SHALL hold the state enum type (EMPTY, BUSY, FULL) and the STALL_CNT_W = 16 constant.
REQ-031 The block SHALL be a single module with no sub-modules; the counter SHALL be inline.

Verification
REQ-032 Reset, then in_valid=1 with in_data=0x11, out_ready=1: out_data=0x11 and out_valid=1 after one edge; in_ready stays 1.
REQ-033 Stream 0x01..0x08 with out_ready=1 throughout: eight consecutive output transfers in order with no bubbles.
REQ-034 Stall: from BUSY holding 0xA0, present 0xA1 with out_ready=0: state FULL, in_ready=0, out_data stays 0xA0; raise out_ready: outputs 0xA0 then 0xA1.
REQ-035 Random in_valid/out_ready (1000 cycles, 50% each): the output sequence equals the input sequence; there is no combinational input-to-output path (check by lint/STA).
REQ-036 Assert reset_n low while FULL: out_valid=0 and in_ready=0 immediately; in_ready=1 one edge after release; no stale data is emitted.
REQ-037 With SKID_STALL_CNT_EN defined: hold out_ready=0 for 5 cycles with out_valid=1, so stall_cnt=5; force 70000 stalls, so stall_cnt=0xFFFF.

Source files
------------

// File: rtl/skid_pkg.sv
// Shared types and constants for the skid buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package skid_pkg;

    // EMPTY: nothing held; BUSY: main register full; FULL: main and skid full.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/skid_buffer.sv
// Fully registered skid buffer: main + skid register, every output driven from a flop.
// Latency: one edge from input transfer to out_valid/out_data; one word per cycle sustained.
// Backpressure: in_ready drops one edge after a stall fills the skid register; optional stall_cnt under SKID_STALL_CNT_EN.
module skid_buffer
    import skid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
`ifdef SKID_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    state_t       state;
    logic [W-1:0] skid;
    logic         take;

    // A word is only taken when the registered in_ready was high at the edge.
    assign take = in_valid & in_ready;

    // Occupancy FSM; in_ready/out_valid are registered alongside the state.
    // in_ready is held low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            out_data  <= '0;
            skid      <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (take) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (take && out_ready) begin
                        out_data <= in_data;
                    end else if (take) begin
                        skid     <= in_data;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    // Upstream is already blocked, so in_valid plays no part here.
                    if (out_ready) begin
                        out_data <= skid;
                        in_ready <= 1'b1;
                        state    <= BUSY;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef SKID_STALL_CNT_EN
    // Saturating count of edges where a held word was refused downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer against a queue-based occupancy model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: model accepts while fewer than two words are held and in_ready is armed.
module tb_skid_buffer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
`ifdef SKID_STALL_CNT_EN
    logic [15:0]  stall_cnt;
    int           m_stall = 0;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: words held in order, plus whether in_ready has been armed since reset.
    logic [W-1:0] mq[$];
    bit           m_armed = 1'b0;

    skid_buffer #(.W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic bit exp_ready();
        return m_armed && (mq.size() < 2);
    endfunction

    function automatic bit exp_valid();
        return mq.size() > 0;
    endfunction

    // Advance one rising edge, update the model from the pre-edge inputs, settle.
    task automatic cycle();
        bit acc;
        bit pop;
        @(posedge clk);
        if (reset_n) begin
            acc = in_valid && exp_ready();
            pop = exp_valid() && out_ready;
`ifdef SKID_STALL_CNT_EN
            if (exp_valid() && !out_ready && m_stall < 65535) m_stall++;
`endif
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
            m_armed = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_before_edge got=%b exp=0", in_ready); end
        cycle();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after_edge got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_after_edge got=%b exp=0", out_valid); end
    endtask

    task automatic test_single();
        in_valid  = 1'b1;
        in_data   = 8'h11;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        total++; if (out_data !== 8'h11) begin bad++; $display("FAIL single_data got=%h exp=11", out_data); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", in_ready); end
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            cycle();
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                bad++;
                $display("FAIL stream_word%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 8'(i));
            end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d got=%b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b exp=0", out_valid); end
    endtask

    task automatic test_stall();
        in_valid  = 1'b1;
        in_data   = 8'hA0;
        out_ready = 1'b1;
        cycle();
        total++; if (out_data !== 8'hA0) begin bad++; $display("FAIL stall_busy_data got=%h exp=a0", out_data); end
        in_data   = 8'hA1;
        out_ready = 1'b0;
        cycle();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_full_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_full_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'hA0) begin bad++; $display("FAIL stall_full_data got=%h exp=a0", out_data); end
        // Upstream keeps offering a word that must be ignored while full.
        in_data = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++; if (out_data !== 8'hA0) begin bad++; $display("FAIL stall_hold_data%0d got=%h exp=a0", i, out_data); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_hold_ready%0d got=%b exp=0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        total++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin bad++; $display("FAIL stall_second got=%b/%h exp=1/a1", out_valid, out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        int n_in  = 0;
        int n_out = 0;
        for (int i = 0; i < 1000; i++) begin
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom);
            if (in_valid && exp_ready()) n_in++;
            if (exp_valid() && out_ready) n_out++;
            cycle();
            total++; if (out_valid !== exp_valid()) begin bad++; $display("FAIL rand_valid c%0d got=%b exp=%b", i, out_valid, exp_valid()); end
            total++; if (in_ready !== exp_ready()) begin bad++; $display("FAIL rand_ready c%0d got=%b exp=%b", i, in_ready, exp_ready()); end
            if (exp_valid()) begin
                total++; if (out_data !== mq[0]) begin bad++; $display("FAIL rand_data c%0d got=%h exp=%h", i, out_data, mq[0]); end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (exp_valid()) n_out++;
            cycle();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_drain got=%b exp=0", out_valid); end
        total++; if (n_out != n_in) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", n_out, n_in); end
    endtask

    task automatic test_reset_full();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 8'hC0;
        cycle();
        in_data   = 8'hC1;
        cycle();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rfull_setup got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        mq.delete();
        m_armed = 1'b0;
`ifdef SKID_STALL_CNT_EN
        m_stall = 0;
`endif
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rfull_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rfull_ready got=%b exp=0", in_ready); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rfull_data got=%h exp=00", out_data); end
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        cycle();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rfull_release_ready got=%b exp=1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rfull_stale%0d got=%b/%h exp=0", i, out_valid, out_data); end
            cycle();
        end
    endtask

`ifdef SKID_STALL_CNT_EN
    task automatic test_stall_cnt();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        mq.delete();
        m_armed = 1'b0;
        m_stall = 0;
        #1;
        total++; if (stall_cnt !== 16'h0000) begin bad++; $display("FAIL scnt_reset got=%h exp=0000", stall_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL scnt_five got=%0d exp=5", stall_cnt); end
        for (int i = 0; i < 70000; i++) cycle();
        total++; if (stall_cnt !== 16'hFFFF || m_stall != 65535) begin bad++; $display("FAIL scnt_sat got=%h exp=ffff", stall_cnt); end
        out_ready = 1'b1;
        cycle();
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL scnt_hold got=%h exp=ffff", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_random();
        test_reset_full();
`ifdef SKID_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
